// File: rtl/uart_rx_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_fifo_pkg
// Brief   : Register-map bit positions and status-word packing shared by the
//           UART receive buffer and its IO decode.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_rx_fifo_pkg;

  // STATUS register bit positions
  localparam int ST_NEMPTY     = 0;
  localparam int ST_OVR        = 1;
  localparam int ST_FULL       = 2;
  localparam int ST_CNT_LSB    = 8;
  localparam int ST_OVRCNT_LSB = 24;

  // CTRL register bit positions (same IO word as STATUS)
  localparam int CTRL_FLUSH    = 0;
  localparam int CTRL_CLR_OVR  = 1;

  // Assemble the STATUS read word from its fields
  function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                              input logic       full,
                                              input logic       ovr,
                                              input logic       nempty,
                                              input logic [7:0] ovr_cnt);
    logic [31:0] s;
    s = '0;
    s[ST_OVRCNT_LSB +: 8] = ovr_cnt;
    s[ST_CNT_LSB +: 8]    = cnt;
    s[ST_FULL]            = full;
    s[ST_OVR]             = ovr;
    s[ST_NEMPTY]          = nempty;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : sync_fifo
// Brief   : Single-clock FIFO with push/pop/flush, first-word-fall-through
//           output, occupancy count and registered empty flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  do_push;
  logic                  do_pop;

  assign full = (count == FULL_CNT);
  assign dout = mem[rd_ptr];

  // Qualify requests: a full FIFO still accepts a push when a pop frees a slot
  always_comb begin
    do_pop    = pop & (count != '0);
    do_push   = push & (~full | do_pop);
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (do_pop && !do_push)
      count_nxt = count - 1'b1;
  end

  // Storage array; flush or reset discards the incoming word
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and empty flag
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_fifo
// Brief   : Memory-mapped UART receive buffer. Captures every uart_rx byte
//           into a FIFO; DATA read pops, STATUS read reports level/flags,
//           CTRL write flushes and/or clears the sticky overrun flag.
//           Optional macro UART_RX_OVERRUN_CNT_EN adds an 8-bit saturating
//           dropped-byte counter visible in STATUS[31:24].
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_dv,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              data_rd,
  input  logic              stat_rd,
  input  logic              ctrl_wr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rx_nempty
);

  logic [DATA_W-1:0]   fifo_dout;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                flush;
  logic                clr_ovr;
  logic                pop_ok;
  logic                drop;
  logic                overrun;
  logic [7:0]          ovr_cnt_w;
  logic [31:0]         status_w;
  logic [31:0]         data_w;
  logic                unused_wdata;

  assign flush   = ctrl_wr & wdata[CTRL_FLUSH];
  assign clr_ovr = ctrl_wr & wdata[CTRL_CLR_OVR];
  assign pop_ok  = data_rd & ~fifo_empty;
  // A byte is lost only when full with no freeing pop; a flush discards it silently
  assign drop    = rx_dv & fifo_full & ~pop_ok & ~flush;

  assign unused_wdata = ^wdata[31:2];

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_dv),
    .pop   (data_rd),
    .flush (flush),
    .din   (rx_byte),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_nempty = ~fifo_empty;

  // Sticky overrun flag; a new overrun outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset)
      overrun <= 1'b0;
    else if (drop)
      overrun <= 1'b1;
    else if (clr_ovr)
      overrun <= 1'b0;
  end

`ifdef UART_RX_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;

  // Saturating dropped-byte counter; a clear with a same-cycle drop restarts at 1
  always_ff @(posedge clk) begin
    if (reset)
      ovr_cnt <= 8'd0;
    else if (clr_ovr)
      ovr_cnt <= {7'd0, drop};
    else if (drop && ovr_cnt != 8'hFF)
      ovr_cnt <= ovr_cnt + 8'd1;
  end

  assign ovr_cnt_w = ovr_cnt;
`else
  assign ovr_cnt_w = 8'd0;
`endif

  // Count is reported in an 8-bit field; the cast zero-extends small FIFOs
  assign status_w = status_word(8'(fifo_count), fifo_full, overrun,
                                ~fifo_empty, ovr_cnt_w);
  assign data_w   = 32'({1'b1, fifo_dout});

  // Registered read port, held until the next DATA or STATUS strobe
  always_ff @(posedge clk) begin
    if (reset)
      rdata <= '0;
    else if (data_rd)
      rdata <= (pop_ok && !flush) ? data_w : 32'd0;
    else if (stat_rd)
      rdata <= status_w;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_rx_fifo
// Brief   : Self-checking bench for uart_rx_fifo against a queue-based model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        data_rd = 1'b0;
  logic        stat_rd = 1'b0;
  logic        ctrl_wr = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        rx_nempty;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  q[$];
  bit          m_ovr = 1'b0;
  int          m_ovc = 0;
  logic [31:0] exp_rd = 32'h0;

`ifdef UART_RX_OVERRUN_CNT_EN
  localparam logic [31:0] OVC1 = 32'h0100_0000;
`else
  localparam logic [31:0] OVC1 = 32'h0000_0000;
`endif

  uart_rx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .data_rd   (data_rd),
    .stat_rd   (stat_rd),
    .ctrl_wr   (ctrl_wr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rx_nempty (rx_nempty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[15:8] = 8'(q.size());
    s[2]    = (q.size() == DEPTH);
    s[1]    = m_ovr;
    s[0]    = (q.size() != 0);
`ifdef UART_RX_OVERRUN_CNT_EN
    s[31:24] = 8'(m_ovc);
`endif
    return s;
  endfunction

  // Apply one cycle of stimulus and advance the model by the spec's rules
  task automatic step(input bit dv, input logic [7:0] b, input bit drd,
                      input bit srd, input bit cwr, input logic [31:0] wd);
    bit fl, clr, drop;
    rx_dv = dv; rx_byte = b; data_rd = drd; stat_rd = srd; ctrl_wr = cwr; wdata = wd;
    fl = cwr & wd[0];
    clr = cwr & wd[1];
    drop = 1'b0;
    if (drd) exp_rd = (fl || q.size() == 0) ? 32'h0 : {23'b0, 1'b1, q[0]};
    else if (srd) exp_rd = m_status();
    if (fl) q.delete();
    else begin
      if (drd && q.size() > 0) void'(q.pop_front());
      if (dv) begin
        if (q.size() < DEPTH) q.push_back(b);
        else drop = 1'b1;
      end
    end
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (clr) m_ovc = drop ? 1 : 0;
    else if (drop && m_ovc < 255) m_ovc++;
    @(posedge clk); #1;
    rx_dv = 1'b0; data_rd = 1'b0; stat_rd = 1'b0; ctrl_wr = 1'b0; wdata = 32'h0;
  endtask

  task automatic do_reset(input bit dv_in_reset);
    reset = 1'b1; rx_dv = dv_in_reset; rx_byte = 8'h77;
    q.delete(); m_ovr = 1'b0; m_ovc = 0; exp_rd = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0; rx_dv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    checks++; if (rx_nempty !== 1'b0) begin failures++; $display("FAIL reset_nempty got=%b exp=0", rx_nempty); end
    step(0, 8'h00, 0, 1, 0, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_basic();
    step(1, 8'h41, 0, 0, 0, 32'h0);
    step(1, 8'h42, 0, 0, 0, 32'h0);
    checks++; if (rx_nempty !== 1'b1) begin failures++; $display("FAIL basic_nempty got=%b exp=1", rx_nempty); end
    step(0, 8'h00, 1, 0, 0, 32'h0);
    checks++; if (rdata !== 32'h0000_0141) begin failures++; $display("FAIL basic_rd1 got=%h exp=%h", rdata, 32'h141); end
    step(0, 8'h00, 1, 0, 0, 32'h0);
    checks++; if (rdata !== 32'h0000_0142) begin failures++; $display("FAIL basic_rd2 got=%h exp=%h", rdata, 32'h142); end
    step(0, 8'h00, 0, 1, 0, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL basic_status got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_empty_pop();
    step(0, 8'h00, 0, 1, 0, 32'h0);   // leave a nonzero-free baseline
    step(0, 8'h00, 1, 0, 0, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL empty_pop got=%h exp=%h", rdata, 32'h0); end
    step(1, 8'h55, 1, 0, 0, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL empty_pop_dv got=%h exp=%h", rdata, 32'h0); end
    step(0, 8'h00, 0, 1, 0, 32'h0);
    checks++; if (rdata !== 32'h0000_0101) begin failures++; $display("FAIL empty_pop_status got=%h exp=%h", rdata, 32'h101); end
    step(0, 8'h00, 1, 0, 0, 32'h0);
    checks++; if (rdata !== 32'h0000_0155) begin failures++; $display("FAIL empty_pop_byte got=%h exp=%h", rdata, 32'h155); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i <= 16; i++) step(1, 8'(i), 0, 0, 0, 32'h0);
    step(0, 8'h00, 0, 1, 0, 32'h0);
    checks++; if (rdata !== (32'h0000_1007 | OVC1)) begin failures++; $display("FAIL ovr_status got=%h exp=%h", rdata, 32'h1007 | OVC1); end
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1, 0, 0, 32'h0);
      checks++; if (rdata !== (32'h100 | 32'(i))) begin failures++; $display("FAIL ovr_drain[%0d] got=%h exp=%h", i, rdata, 32'h100 | 32'(i)); end
    end
    step(0, 8'h00, 1, 0, 0, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL ovr_lost got=%h exp=%h", rdata, 32'h0); end
    step(0, 8'h00, 0, 1, 0, 32'h0);
    checks++; if (rdata !== (32'h0000_0002 | OVC1)) begin failures++; $display("FAIL ovr_sticky got=%h exp=%h", rdata, 32'h2 | OVC1); end
    step(0, 8'h00, 0, 0, 1, 32'h2);
    step(0, 8'h00, 0, 1, 0, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL ovr_clear got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 32'h0);
    step(1, 8'hAA, 1, 0, 0, 32'h0);
    checks++; if (rdata !== 32'h0000_0120) begin failures++; $display("FAIL fullpop_rd got=%h exp=%h", rdata, 32'h120); end
    step(0, 8'h00, 0, 1, 0, 32'h0);
    checks++; if (rdata !== 32'h0000_1005) begin failures++; $display("FAIL fullpop_status got=%h exp=%h", rdata, 32'h1005); end
    for (int i = 1; i <= 16; i++) begin
      logic [31:0] e;
      e = (i == 16) ? 32'h1AA : (32'h100 | 32'(8'h20 + i));
      step(0, 8'h00, 1, 0, 0, 32'h0);
      checks++; if (rdata !== e) begin failures++; $display("FAIL fullpop_drain[%0d] got=%h exp=%h", i, rdata, e); end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 32'h0);
    step(1, 8'h99, 0, 0, 1, 32'h3);
    checks++; if (rx_nempty !== 1'b0) begin failures++; $display("FAIL flush_nempty got=%b exp=0", rx_nempty); end
    step(0, 8'h00, 0, 1, 0, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL flush_status got=%h exp=%h", rdata, 32'h0); end
    step(0, 8'h00, 1, 0, 0, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL flush_data got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_wrap();
    step(1, 8'($urandom), 0, 0, 0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      step(1, 8'($urandom), 1, 0, 0, 32'h0);
      checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL wrap[%0d] got=%h exp=%h", i, rdata, exp_rd); end
    end
    while (q.size() > 0) step(0, 8'h00, 1, 0, 0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit dv, drd, srd, cwr;
      dv  = ($urandom_range(0, 99) < 60);
      drd = ($urandom_range(0, 99) < 35);
      srd = !drd && ($urandom_range(0, 99) < 20);
      cwr = ($urandom_range(0, 99) < 4);
      step(dv, 8'($urandom), drd, srd, cwr, {30'($urandom), 2'($urandom)});
      checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, rdata, exp_rd); end
      checks++; if (rx_nempty !== (q.size() != 0)) begin failures++; $display("FAIL rand_nempty[%0d] got=%b exp=%b", i, rx_nempty, q.size() != 0); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0, 0, 32'h0);
    step(0, 8'h00, 0, 1, 0, 32'h0);
    do_reset(1'b1);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rdata got=%h exp=%h", rdata, 32'h0); end
    checks++; if (rx_nempty !== 1'b0) begin failures++; $display("FAIL rstmid_nempty got=%b exp=0", rx_nempty); end
    step(0, 8'h00, 0, 1, 0, 32'h0);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rstmid_status got=%h exp=%h", rdata, 32'h0); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_empty_pop();
    test_overrun();
    test_full_pop();
    test_flush();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
